// File: rtl/reg_hazard_ctrl.sv
// Register hazard controller: tracks in-flight writes in EX/MEM/WB, resolves
// per-source forwarding selects, and raises stall for RAW/load-use hazards.

module reg_hazard_src (
  input  logic            use_i,
  input  logic [4:0]      addr_i,
  input  logic [2:0]      slot_v,   // [0]=EX, [1]=MEM, [2]=WB
  input  logic [2:0][4:0] slot_da,
  input  logic            mem_ld,
  output logic            hazard,
  output logic [1:0]      sel
);
  logic live;

  always_comb begin
    hazard = 1'b0;
    sel    = 2'b00;
    live   = use_i && (addr_i != 5'd0);
    // Youngest match wins: EX first, then MEM, then WB.
    if (live) begin
      if (slot_v[0] && slot_da[0] == addr_i) begin
        hazard = 1'b1;
      end else if (slot_v[1] && slot_da[1] == addr_i) begin
        if (mem_ld) hazard = 1'b1;
        else        sel    = 2'b01;
      end else if (slot_v[2] && slot_da[2] == addr_i) begin
        sel = 2'b10;
      end
    end
  end
endmodule

module reg_hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic        issue_rw,
  input  logic        issue_ld,
  input  logic [4:0]  issue_da,
  input  logic [4:0]  issue_aa,
  input  logic [4:0]  issue_ba,
  input  logic        issue_use_a,
  input  logic        issue_use_b,
  input  logic        flush,
  input  logic        mem_ready,
  output logic        stall,
  output logic [1:0]  ha,
  output logic [1:0]  hb,
  output logic        wb_rw,
  output logic [4:0]  wb_da,
  output logic [15:0] stall_cnt
);
  localparam int NUM_SRC = 2;

  typedef struct packed {
    logic       v;
    logic       ld;
    logic [4:0] da;
  } slot_t;

  slot_t       ex_q, ex_d, mem_q, mem_d, issue_ent;
  // WB keeps no load flag: nothing after WB needs it.
  logic        wb_v_q, wb_v_d;
  logic [4:0]  wb_da_q, wb_da_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic                      mem_hold, issue_fire;
  logic [NUM_SRC-1:0]        src_use, src_haz;
  logic [NUM_SRC-1:0][4:0]   src_addr;
  logic [NUM_SRC-1:0][1:0]   src_sel;
  logic [2:0]                slot_v;
  logic [2:0][4:0]           slot_da;

  assign src_use  = {issue_use_b, issue_use_a};
  assign src_addr = {issue_ba, issue_aa};
  assign slot_v   = {wb_v_q, mem_q.v, ex_q.v};
  assign slot_da  = {wb_da_q, mem_q.da, ex_q.da};

  generate
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      reg_hazard_src u_src (
        .use_i   (src_use[s]),
        .addr_i  (src_addr[s]),
        .slot_v  (slot_v),
        .slot_da (slot_da),
        .mem_ld  (mem_q.ld),
        .hazard  (src_haz[s]),
        .sel     (src_sel[s])
      );
    end
  endgenerate

  always_comb begin
    mem_hold   = mem_q.v & mem_q.ld & ~mem_ready;
    stall      = mem_hold | (issue_valid & (|src_haz));
    issue_fire = issue_valid & ~stall & ~flush;

    issue_ent    = '0;
    issue_ent.v  = 1'b1;
    issue_ent.ld = issue_ld;
    issue_ent.da = issue_da;

    ex_d    = '0;
    mem_d   = mem_q;
    wb_v_d  = 1'b0;
    wb_da_d = 5'd0;

    if (mem_hold) begin
      // Load waiting on memory: EX/MEM freeze, WB drains.
      ex_d = flush ? '0 : ex_q;
    end else begin
      wb_v_d  = mem_q.v;
      wb_da_d = mem_q.da;
      mem_d   = flush ? '0 : ex_q;
      if (issue_fire && issue_rw && issue_da != 5'd0) ex_d = issue_ent;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && issue_valid && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_v_q      <= 1'b0;
      wb_da_q     <= 5'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_v_q      <= wb_v_d;
      wb_da_q     <= wb_da_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ha        = src_sel[0];
  assign hb        = src_sel[1];
  assign wb_rw     = wb_v_q;
  assign wb_da     = wb_da_q;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_reg_hazard_ctrl.sv
// Bench for reg_hazard_ctrl: directed vector table, reset/saturation sequences,
// and random traffic against a queue-based model of the in-flight writes.

module tb_reg_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_rw, issue_ld, issue_use_a, issue_use_b;
  logic [4:0]  issue_da, issue_aa, issue_ba;
  logic        flush, mem_ready;
  logic        stall, wb_rw;
  logic [1:0]  ha, hb;
  logic [4:0]  wb_da;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rw(issue_rw), .issue_ld(issue_ld),
    .issue_da(issue_da), .issue_aa(issue_aa), .issue_ba(issue_ba),
    .issue_use_a(issue_use_a), .issue_use_b(issue_use_b),
    .flush(flush), .mem_ready(mem_ready),
    .stall(stall), .ha(ha), .hb(hb),
    .wb_rw(wb_rw), .wb_da(wb_da), .stall_cnt(stall_cnt)
  );

  typedef struct {
    bit iv, rw, ld;
    int da, aa, ba;
    bit ua, ub, fl, mr;
    bit st;
    int eha, ehb;
    bit wr;
    int wd, cnt;
  } vec_t;

  typedef struct {
    bit v;
    bit ld;
    int da;
  } ent_t;

  vec_t tbl[$];
  ent_t mq[$];   // in-flight writes, [0]=youngest (EX) .. [2]=WB
  int   mcnt;

  function automatic vec_t mk(bit iv, bit rw, bit ld, int da, int aa, int ba,
                              bit ua, bit ub, bit fl, bit mr,
                              bit st, int eha, int ehb, bit wr, int wd, int cnt);
    vec_t r;
    r.iv = iv; r.rw = rw; r.ld = ld; r.da = da; r.aa = aa; r.ba = ba;
    r.ua = ua; r.ub = ub; r.fl = fl; r.mr = mr;
    r.st = st; r.eha = eha; r.ehb = ehb; r.wr = wr; r.wd = wd; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input bit iv, input bit rw, input bit ld, input int da,
                       input int aa, input int ba, input bit ua, input bit ub,
                       input bit fl, input bit mr);
    issue_valid = iv; issue_rw = rw; issue_ld = ld;
    issue_da = 5'(da); issue_aa = 5'(aa); issue_ba = 5'(ba);
    issue_use_a = ua; issue_use_b = ub; flush = fl; mem_ready = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Model lookup: first in-flight write (youngest first) naming this source.
  function automatic void look(input bit u, input int a, output bit hz, output int sel);
    bit found = 0;
    hz = 0; sel = 0;
    if (u && a != 0) begin
      for (int k = 0; k < 3; k++) begin
        if (!found && mq[k].v && mq[k].da == a) begin
          found = 1;
          if (k == 0)      hz = 1;
          else if (k == 1) begin if (mq[k].ld) hz = 1; else sel = 1; end
          else             sel = 2;
        end
      end
    end
  endfunction

  function automatic ent_t bub();
    ent_t e;
    e.v = 0; e.ld = 0; e.da = 0;
    return e;
  endfunction

  function automatic void model_clear();
    mq.delete();
    for (int k = 0; k < 3; k++) mq.push_back(bub());
    mcnt = 0;
  endfunction

  initial begin
    bit   hza, hzb, hold, mst, fire;
    int   sa, sb;
    ent_t ne;

    rst_n = 1'b0;
    idle();
    tick();
    tick();
    @(negedge clk);
    chk("reset wb_rw", wb_rw, 0);
    chk("reset wb_da", wb_da, 0);
    chk("reset stall", stall, 0);
    chk("reset ha", ha, 0);
    chk("reset hb", hb, 0);
    chk("reset stall_cnt", stall_cnt, 0);
    rst_n = 1'b1;
    tick();

    //            iv rw ld da  aa ba ua ub fl mr   st ha hb wr wd cnt
    // ALU result forwarded from MEM after one stall
    tbl.push_back(mk(1, 1, 0, 3,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  3, 0, 1, 0, 0, 1,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  3, 0, 1, 0, 0, 1,  0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 3, 1));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1));
    // load-use: two stalls then WB bus
    tbl.push_back(mk(1, 1, 1, 5,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0,  0, 5, 0, 1, 0, 1,  1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0,  0, 5, 0, 1, 0, 1,  1, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0,  0, 5, 0, 1, 0, 1,  0, 0, 2, 1, 5, 3));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 3));
    // load held in MEM for three cycles
    tbl.push_back(mk(1, 1, 1, 7,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 7, 3));
    // flush squashes R4
    tbl.push_back(mk(1, 1, 0, 4,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1, 0, 0, 0,  4, 0, 1, 0, 0, 1,  0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 3));
    // writes to R0 are never tracked
    tbl.push_back(mk(1, 1, 0, 0,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1, 1, 1, 0,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 1, 1, 0, 1,  0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 3));
    // R9 twice: youngest (SUB in MEM) wins
    tbl.push_back(mk(1, 1, 0, 9,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1, 1, 0, 9,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1, 0, 0, 0,  9, 0, 1, 0, 0, 1,  1, 0, 0, 1, 9, 3));
    tbl.push_back(mk(1, 0, 0, 0,  9, 0, 1, 0, 0, 1,  0, 1, 0, 0, 0, 4));
    // R6 in MEM and WB at once; unused A source ignored
    tbl.push_back(mk(1, 1, 0, 6,  0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 9, 4));
    tbl.push_back(mk(1, 1, 0, 6,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(1, 0, 0, 0,  6, 6, 0, 1, 0, 1,  0, 0, 1, 1, 6, 4));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 6, 4));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 4));

    foreach (tbl[i]) begin
      drive(tbl[i].iv, tbl[i].rw, tbl[i].ld, tbl[i].da, tbl[i].aa, tbl[i].ba,
            tbl[i].ua, tbl[i].ub, tbl[i].fl, tbl[i].mr);
      @(negedge clk);
      chk($sformatf("row%0d stall", i), stall, tbl[i].st);
      if (!tbl[i].st) begin
        chk($sformatf("row%0d ha", i), ha, tbl[i].eha);
        chk($sformatf("row%0d hb", i), hb, tbl[i].ehb);
      end
      chk($sformatf("row%0d wb_rw", i), wb_rw, tbl[i].wr);
      chk($sformatf("row%0d wb_da", i), wb_da, tbl[i].wd);
      chk($sformatf("row%0d stall_cnt", i), stall_cnt, tbl[i].cnt);
      tick();
    end

    // Reset with three writes in flight: none may reach the regfile.
    drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 1); tick();
    drive(1, 1, 0, 2, 0, 0, 0, 0, 0, 1); tick();
    drive(1, 1, 0, 3, 0, 0, 0, 0, 0, 1); tick();
    rst_n = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("midreset c%0d wb_rw", c), wb_rw, 0);
      chk($sformatf("midreset c%0d stall", c), stall, 0);
      chk($sformatf("midreset c%0d stall_cnt", c), stall_cnt, 0);
      tick();
    end

    // Random traffic against the model.
    do_reset();
    model_clear();
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
            $urandom_range(0, 99) < 8, $urandom_range(0, 3) != 0);
      @(negedge clk);
      look(issue_use_a, int'(issue_aa), hza, sa);
      look(issue_use_b, int'(issue_ba), hzb, sb);
      hold = mq[1].v && mq[1].ld && !mem_ready;
      mst  = hold || (issue_valid && (hza || hzb));
      chk($sformatf("rnd%0d stall", n), stall, mst);
      if (!hza) chk($sformatf("rnd%0d ha", n), ha, sa);
      if (!hzb) chk($sformatf("rnd%0d hb", n), hb, sb);
      chk($sformatf("rnd%0d wb_rw", n), wb_rw, mq[2].v);
      chk($sformatf("rnd%0d wb_da", n), wb_da, mq[2].da);
      chk($sformatf("rnd%0d stall_cnt", n), stall_cnt, mcnt);
      if (!rst_n) begin
        model_clear();
      end else begin
        fire = issue_valid && !mst && !flush;
        if (hold) begin
          mq[2] = bub();
          if (flush) mq[0] = bub();
        end else begin
          void'(mq.pop_back());
          if (flush) mq[0] = bub();
          ne = bub();
          if (fire && issue_rw && issue_da != 0) begin
            ne.v = 1; ne.ld = issue_ld; ne.da = int'(issue_da);
          end
          mq.push_front(ne);
        end
        if (mst && issue_valid && mcnt < 65535) mcnt++;
      end
      tick();
    end
    rst_n = 1'b1;

    // Long load stall with decode waiting: counter must saturate.
    do_reset();
    drive(1, 1, 1, 1, 0, 0, 0, 0, 0, 1); tick();
    idle(); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 65534; c++) @(posedge clk);
    #1;
    @(negedge clk);
    chk("sat stall", stall, 1);
    chk("sat cnt 65534", stall_cnt, 16'hFFFE);
    tick();
    @(negedge clk);
    chk("sat cnt 65535", stall_cnt, 16'hFFFF);
    tick(); tick();
    @(negedge clk);
    chk("sat cnt hold", stall_cnt, 16'hFFFF);
    chk("sat wb_rw", wb_rw, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_hazard_ctrl.md
REG_HAZARD_CTRL -- requirements
Module: reg_hazard_ctrl

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst_n  in  1  reset, synchronous, active-low; clock clk.
REQ-003 issue_valid  in  1  decode stage holds an instruction requesting issue.
REQ-004 issue_rw  in  1  issuing instruction writes a destination register.
REQ-005 issue_ld  in  1  issuing instruction is a load, with data at end of MEM.
REQ-006 issue_da  in  5  destination register address.
REQ-007 issue_aa, issue_ba  in  5 each  source A/B register addresses.
REQ-008 issue_use_a, issue_use_b  in  1 each  source A/B is actually read.
REQ-009 flush  in  1  squash the instructions in decode and EX this cycle.
REQ-010 mem_ready  in  1  load data valid; only consulted when MEM slot holds a load.
REQ-011 stall  out  1  combinational; decode must hold its instruction.
REQ-012 ha, hb  out  2 each  combinational operand select: 00 regfile, 01 MEM-stage ALU result, 10 WB bus.
REQ-013 wb_rw, wb_da  out  1/5  registered regfile write enable/address, driven from WB slot.
REQ-014 stall_cnt  out  16  saturating count of stalled issue cycles.

Function
REQ-015 Three tracking slots EX, MEM, WB SHALL each hold {v, ld, da}; v=1 only for instructions with rw=1 and da!=0.
REQ-016 issue_fire SHALL equal issue_valid & !stall & !flush.
REQ-017 mem_hold SHALL equal MEM.v & MEM.ld & !mem_ready.
REQ-018 A source is live when its use bit is 1 and its address is nonzero; non-live sources give select 00 and no hazard.
REQ-019 Live source match priority SHALL be EX, then MEM, then WB (youngest wins).
REQ-020 EX match SHALL raise a hazard (result not yet computed).
REQ-021 MEM match with ld=1 SHALL raise a hazard; with ld=0 SHALL select 01.
REQ-022 WB match SHALL select 10; no match SHALL select 00.
REQ-023 stall SHALL equal mem_hold | (issue_valid & (hazard_a | hazard_b)).
REQ-024 ha/hb are meaningful only when stall=0, but SHALL follow REQ-019..022 in every cycle.
REQ-025 Normal advance (mem_hold=0) SHALL be WB<=MEM, MEM<=EX, EX<=issued entry if issue_fire & issue_rw & issue_da!=0, else bubble.
REQ-026 During mem_hold, EX and MEM SHALL hold and WB SHALL take a bubble.
REQ-027 On flush with mem_hold=0, MEM<=bubble (squashed EX) and EX<=bubble; WB<=MEM still advances.
REQ-028 On flush with mem_hold=1, EX<=bubble, MEM holds, WB<=bubble.
REQ-029 wb_rw=WB.v and wb_da=WB.da; the regfile write occurs at the edge ending the WB cycle, so the earliest bypass-free read is the following cycle.
REQ-030 Writes to address 0 SHALL never be tracked and never assert wb_rw.
REQ-031 stall_cnt SHALL increment when stall & issue_valid, and hold at 16'hFFFF.
REQ-032 Back-to-back writes to the same register SHALL each occupy their own slot; forwarding SHALL use the youngest.

Reset
REQ-033 While rst_n=0 at a clk edge, all slots SHALL clear to v=0, ld=0, da=0 and stall_cnt SHALL clear to 0.
REQ-034 After reset, wb_rw=0, wb_da=0, and with issue_valid=0: stall=0, ha=hb=00.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight entries with no wb_rw pulse afterward.

Verification
REQ-036 Sequence: ADD R3 at t, then a use of R3 at t+1 -> t+1: stall=1; t+2: ha=01, stall=0; stall_cnt=1.
REQ-037 Sequence: LD R5 at t, then a use of R5 as B at t+1 -> stall at t+1 and t+2; t+3: hb=10; wb_rw=1, wb_da=5 at t+3.
REQ-038 LD R7 in MEM with mem_ready=0 for 3 cycles -> stall=1 for 3 cycles; MEM held; WB bubbles; wb_rw=0; then wb_rw=1, wb_da=7 one cycle after mem_ready=1.
REQ-039 ADD R4 at t, flush at t+1 -> no wb_rw for R4; a use of R4 at t+2 gives ha=00, stall=0.
REQ-040 Issue of writes to R0, then a use of R0 -> no stall, ha=00, wb_rw never 1.
REQ-041 ADD R9 at t, SUB R9 at t+2, and a use of R9 at t+3 -> stall at t+3; at t+4: ha=01 (SUB, in MEM), not 10.
